// File: rtl/mem_if_pkg.sv
// Shared memory-interface definitions: line/beat geometry, data types and
// the cacheline adaptor state encoding.
package mem_if_pkg;

  localparam int S_LINE  = 256;
  localparam int S_BURST = 64;
  localparam int S_BEATS = S_LINE / S_BURST;

  typedef logic [S_LINE-1:0]  line_t;
  typedef logic [S_BURST-1:0] beat_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    DONE  = 2'b11
  } adaptor_state_e;

endpackage

// File: rtl/cacheline_adaptor.sv
// Cacheline adaptor: turns one line read/write request from the arbiter into
// a fixed-order burst of s_beats beats on the physical memory bus and answers
// with a single-cycle line_resp. One transaction in flight at a time.
// Beat 0 carries line bits [s_burst-1:0]; beats ascend from there.
module cacheline_adaptor
  import mem_if_pkg::*;
#(
  parameter int s_line  = S_LINE,
  parameter int s_burst = S_BURST,
  parameter int s_beats = s_line / s_burst
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               line_read,
  input  logic               line_write,
  input  logic [31:0]        line_addr,
  input  logic [s_line-1:0]  line_wdata,
  output logic [s_line-1:0]  line_rdata,
  output logic               line_resp,
  output logic               burst_read,
  output logic               burst_write,
  output logic [31:0]        burst_addr,
  output logic [s_burst-1:0] burst_wdata,
  input  logic [s_burst-1:0] burst_rdata,
  input  logic               burst_resp
);

  localparam int cnt_w = $clog2(s_beats);
  localparam int off_w = $clog2(s_line / 8);
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(s_beats - 1);

  adaptor_state_e      state_r;
  logic [cnt_w-1:0]    cnt_r;
  logic [cnt_w-1:0]    cnt_nxt_s;
  logic [s_line-1:0]   buffer_r;
  logic [31:0]         addr_r;
  logic [s_burst-1:0]  burst_wdata_r;
  logic                burst_read_r;
  logic                burst_write_r;
  logic                line_resp_r;

  // Byte offset within the line is dropped by alignment; kept only for lint.
  logic                unused_offset_s;
  assign unused_offset_s = ^line_addr[off_w-1:0];

  // Beat counter successor; wraps naturally at s_beats.
  always_comb begin
    cnt_nxt_s = cnt_r + 1'b1;
  end

  // Single FSM: accepts a request in IDLE, runs the burst, pulses line_resp.
  // All outputs are registers so nothing combinational reaches the ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      cnt_r         <= '0;
      buffer_r      <= '0;
      addr_r        <= 32'h0000_0000;
      burst_wdata_r <= '0;
      burst_read_r  <= 1'b0;
      burst_write_r <= 1'b0;
      line_resp_r   <= 1'b0;
    end else begin
      line_resp_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (line_write) begin
            // Write has priority when both requests are raised together.
            buffer_r      <= line_wdata;
            addr_r        <= {line_addr[31:off_w], {off_w{1'b0}}};
            cnt_r         <= '0;
            burst_wdata_r <= line_wdata[s_burst-1:0];
            burst_write_r <= 1'b1;
            state_r       <= WRITE;
          end else if (line_read) begin
            addr_r        <= {line_addr[31:off_w], {off_w{1'b0}}};
            cnt_r         <= '0;
            burst_wdata_r <= '0;
            burst_read_r  <= 1'b1;
            state_r       <= READ;
          end else begin
            state_r <= IDLE;
          end
        end
        READ: begin
          if (burst_resp) begin
            buffer_r[s_burst*cnt_r +: s_burst] <= burst_rdata;
            cnt_r <= cnt_nxt_s;
            if (cnt_r == last_beat) begin
              burst_read_r <= 1'b0;
              line_resp_r  <= 1'b1;
              state_r      <= DONE;
            end else begin
              state_r <= READ;
            end
          end else begin
            state_r <= READ;
          end
        end
        WRITE: begin
          if (burst_resp) begin
            cnt_r <= cnt_nxt_s;
            if (cnt_r == last_beat) begin
              burst_wdata_r <= '0;
              burst_write_r <= 1'b0;
              line_resp_r   <= 1'b1;
              state_r       <= DONE;
            end else begin
              // Present the next beat; it stays put across response gaps.
              burst_wdata_r <= buffer_r[s_burst*cnt_nxt_s +: s_burst];
              state_r       <= WRITE;
            end
          end else begin
            state_r <= WRITE;
          end
        end
        DONE: begin
          // Requests are not sampled here; a new one waits for IDLE.
          state_r <= IDLE;
        end
        default: begin
          burst_read_r  <= 1'b0;
          burst_write_r <= 1'b0;
          state_r       <= IDLE;
        end
      endcase
    end
  end

  assign line_rdata  = buffer_r;
  assign line_resp   = line_resp_r;
  assign burst_read  = burst_read_r;
  assign burst_write = burst_write_r;
  assign burst_addr  = addr_r;
  assign burst_wdata = burst_wdata_r;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor. The bench plays the burst memory:
// it answers beats from a reference line (reads) or collects written beats,
// and compares against expectations derived from the line-level behaviour.
module tb_cacheline_adaptor;

  logic         clk;
  logic         rst;
  logic         line_read;
  logic         line_write;
  logic [31:0]  line_addr;
  logic [255:0] line_wdata;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic         burst_read;
  logic         burst_write;
  logic [31:0]  burst_addr;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;

  int n_checks = 0;
  int n_fail   = 0;

  // Results of the last transaction run by run_txn
  logic [255:0] r_rdata;
  logic [255:0] r_wbeats;
  logic [31:0]  r_addr;
  int           r_rd_cycles;
  int           r_wr_cycles;
  int           r_resp_cycle;
  int           r_resp_count;
  int           r_wdata_bad;
  logic         r_timeout;

  cacheline_adaptor dut (
    .clk         (clk),
    .rst         (rst),
    .line_read   (line_read),
    .line_write  (line_write),
    .line_addr   (line_addr),
    .line_wdata  (line_wdata),
    .line_rdata  (line_rdata),
    .line_resp   (line_resp),
    .burst_read  (burst_read),
    .burst_write (burst_write),
    .burst_addr  (burst_addr),
    .burst_wdata (burst_wdata),
    .burst_rdata (burst_rdata),
    .burst_resp  (burst_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(negedge clk);
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom;
    return l;
  endfunction

  // Issue one request and act as the memory until line_resp plus one cycle.
  // Called at a negedge; returns at the negedge observing the cycle after DONE.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [255:0] wline, input logic [255:0] mline,
                         input int gap, input logic hold);
    int beats;
    int gctr;
    int cyc;
    line_read  = rd;
    line_write = wr;
    line_addr  = addr;
    line_wdata = wline;
    r_rdata = '0; r_wbeats = '0; r_addr = 32'h0;
    r_rd_cycles = 0; r_wr_cycles = 0; r_resp_cycle = 0; r_resp_count = 0;
    r_wdata_bad = 0; r_timeout = 1'b0;
    step;
    if (!hold) begin
      line_read  = 1'b0;
      line_write = 1'b0;
      line_addr  = $urandom;
      line_wdata = rand_line();
    end
    beats = 0;
    gctr  = 0;
    for (cyc = 1; cyc <= 80; cyc++) begin
      if (burst_read)  r_rd_cycles++;
      if (burst_write) r_wr_cycles++;
      if (cyc == 1) r_addr = burst_addr;
      if (line_resp) begin
        r_resp_count++;
        if (r_resp_cycle == 0) begin
          r_resp_cycle = cyc;
          r_rdata = line_rdata;
        end
      end
      if (burst_write && beats < 4 && burst_wdata !== wline[64*beats +: 64]) r_wdata_bad++;
      if (r_resp_cycle != 0 && cyc == r_resp_cycle + 1) begin
        burst_resp = 1'b0;
        break;
      end
      if ((burst_read || burst_write) && beats < 4 && gctr == 0) begin
        burst_resp  = 1'b1;
        burst_rdata = mline[64*beats +: 64];
        if (burst_write) r_wbeats[64*beats +: 64] = burst_wdata;
        beats++;
        gctr = gap;
      end else begin
        burst_resp  = 1'b0;
        burst_rdata = {$urandom, $urandom};
        if (gctr > 0) gctr--;
      end
      step;
    end
    if (cyc > 80) begin
      r_timeout  = 1'b1;
      burst_resp = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; line_read = 1'b1; line_write = 1'b0; line_addr = 32'hFFFF_FFFF;
    line_wdata = rand_line(); burst_resp = 1'b1; burst_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    repeat (3) step;
    n_checks++;
    if ({burst_read, burst_write, line_resp} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 000", {burst_read, burst_write, line_resp});
    end
    n_checks++;
    if (line_rdata !== 256'h0 || burst_addr !== 32'h0 || burst_wdata !== 64'h0) begin
      n_fail++; $display("FAIL reset_data: rdata %h addr %h wdata %h expected zeros", line_rdata, burst_addr, burst_wdata);
    end
    rst = 1'b0; line_read = 1'b0; burst_resp = 1'b0;
    step;
    n_checks++;
    if ({burst_read, burst_write, line_resp} !== 3'b000) begin
      n_fail++; $display("FAIL idle_after_reset: got %b expected 000", {burst_read, burst_write, line_resp});
    end
  endtask

  task automatic test_read;
    logic [255:0] m;
    m = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
    run_txn(1'b1, 1'b0, 32'h0000_1234, 256'h0, m, 0, 1'b0);
    n_checks++;
    if (r_timeout !== 1'b0) begin n_fail++; $display("FAIL read_timeout: got %b expected 0", r_timeout); end
    n_checks++;
    if (r_addr !== 32'h0000_1220) begin n_fail++; $display("FAIL read_addr: got %h expected 00001220", r_addr); end
    n_checks++;
    if (r_resp_cycle !== 5 || r_resp_count !== 1) begin
      n_fail++; $display("FAIL read_resp: cycle %0d count %0d expected cycle 5 count 1", r_resp_cycle, r_resp_count);
    end
    n_checks++;
    if (r_rd_cycles !== 4 || r_wr_cycles !== 0) begin
      n_fail++; $display("FAIL read_req_cycles: rd %0d wr %0d expected rd 4 wr 0", r_rd_cycles, r_wr_cycles);
    end
    n_checks++;
    if (r_rdata !== m) begin n_fail++; $display("FAIL read_data: got %h expected %h", r_rdata, m); end
  endtask

  task automatic test_write_gaps;
    logic [255:0] w;
    w = rand_line();
    run_txn(1'b0, 1'b1, 32'hABCD_EF7F, w, rand_line(), 2, 1'b0);
    n_checks++;
    if (r_timeout !== 1'b0) begin n_fail++; $display("FAIL write_timeout: got %b expected 0", r_timeout); end
    n_checks++;
    if (r_addr !== 32'hABCD_EF60) begin n_fail++; $display("FAIL write_addr: got %h expected abcdef60", r_addr); end
    n_checks++;
    if (r_wbeats !== w) begin n_fail++; $display("FAIL write_beats: got %h expected %h", r_wbeats, w); end
    n_checks++;
    if (r_wdata_bad !== 0) begin n_fail++; $display("FAIL write_stable: %0d bad wdata cycles expected 0", r_wdata_bad); end
    n_checks++;
    if (r_wr_cycles !== 10 || r_rd_cycles !== 0) begin
      n_fail++; $display("FAIL write_req_cycles: wr %0d rd %0d expected wr 10 rd 0", r_wr_cycles, r_rd_cycles);
    end
    n_checks++;
    if (r_resp_cycle !== 11 || r_resp_count !== 1) begin
      n_fail++; $display("FAIL write_resp: cycle %0d count %0d expected cycle 11 count 1", r_resp_cycle, r_resp_count);
    end
    n_checks++;
    if (r_rdata !== w) begin n_fail++; $display("FAIL write_rdata: got %h expected %h", r_rdata, w); end
  endtask

  task automatic test_write_priority;
    logic [255:0] w;
    w = rand_line();
    run_txn(1'b1, 1'b1, 32'h0000_0040, w, rand_line(), 0, 1'b0);
    n_checks++;
    if (r_rd_cycles !== 0 || r_wr_cycles !== 4) begin
      n_fail++; $display("FAIL prio_cycles: rd %0d wr %0d expected rd 0 wr 4", r_rd_cycles, r_wr_cycles);
    end
    n_checks++;
    if (r_wbeats !== w || r_wdata_bad !== 0) begin
      n_fail++; $display("FAIL prio_beats: got %h (bad %0d) expected %h", r_wbeats, r_wdata_bad, w);
    end
  endtask

  task automatic test_reset_mid;
    logic [255:0] m;
    int resp_seen;
    m = rand_line();
    line_read = 1'b1; line_addr = 32'h0000_8044;
    step;
    line_read = 1'b0;
    for (int b = 0; b < 2; b++) begin
      burst_resp = 1'b1; burst_rdata = m[64*b +: 64];
      step;
    end
    burst_resp = 1'b0;
    n_checks++;
    if (burst_read !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: burst_read %b expected 1", burst_read); end
    rst = 1'b1;
    step;
    rst = 1'b0;
    n_checks++;
    if ({burst_read, burst_write, line_resp} !== 3'b000 || line_rdata !== 256'h0 || burst_addr !== 32'h0) begin
      n_fail++; $display("FAIL midrst_clear: ctrl %b rdata %h addr %h expected zeros", {burst_read, burst_write, line_resp}, line_rdata, burst_addr);
    end
    resp_seen = 0;
    repeat (3) begin
      if (line_resp) resp_seen++;
      step;
    end
    n_checks++;
    if (resp_seen !== 0) begin n_fail++; $display("FAIL midrst_noresp: %0d responses expected 0", resp_seen); end
    m = rand_line();
    run_txn(1'b1, 1'b0, 32'h0000_8044, 256'h0, m, 1, 1'b0);
    n_checks++;
    if (r_rdata !== m || r_resp_cycle !== 8 || r_rd_cycles !== 7) begin
      n_fail++; $display("FAIL midrst_followup: data %h cycle %0d rd %0d expected %h cycle 8 rd 7", r_rdata, r_resp_cycle, r_rd_cycles, m);
    end
  endtask

  task automatic test_back_to_back;
    logic [255:0] m1;
    logic [255:0] m2;
    m1 = rand_line();
    m2 = rand_line();
    run_txn(1'b1, 1'b0, 32'h1000_0000, 256'h0, m1, 0, 1'b1);
    n_checks++;
    if (r_resp_count !== 1 || r_rd_cycles !== 4 || r_rdata !== m1) begin
      n_fail++; $display("FAIL hold_first: resp %0d rd %0d data %h expected 1 4 %h", r_resp_count, r_rd_cycles, r_rdata, m1);
    end
    // Stray beat while IDLE, with the read still held high
    burst_resp = 1'b1; burst_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    run_txn(1'b1, 1'b0, 32'h2000_0020, 256'h0, m2, 0, 1'b1);
    line_read = 1'b0;
    n_checks++;
    if (r_rd_cycles !== 4 || r_resp_cycle !== 5 || r_addr !== 32'h2000_0020) begin
      n_fail++; $display("FAIL hold_second: rd %0d cycle %0d addr %h expected 4 5 20000020", r_rd_cycles, r_resp_cycle, r_addr);
    end
    n_checks++;
    if (r_rdata !== m2) begin n_fail++; $display("FAIL hold_second_data: got %h expected %h", r_rdata, m2); end
    step;
  endtask

  task automatic test_random;
    logic         wr;
    logic         rd;
    logic [31:0]  addr;
    logic [255:0] w;
    logic [255:0] m;
    logic [255:0] exp_line;
    int           g;
    int           exp_len;
    for (int i = 0; i < 16; i++) begin
      wr   = 1'($urandom_range(0, 1));
      rd   = 1'($urandom_range(0, 1)) | ~wr;
      addr = $urandom;
      w    = rand_line();
      m    = rand_line();
      g    = $urandom_range(0, 2);
      exp_len  = 4 + 3 * g;
      exp_line = wr ? w : m;
      run_txn(rd, wr, addr, w, m, g, 1'b0);
      n_checks++;
      if (r_rdata !== exp_line || r_addr !== (addr & 32'hFFFF_FFE0)) begin
        n_fail++; $display("FAIL rand_%0d_data: data %h addr %h expected %h %h", i, r_rdata, r_addr, exp_line, addr & 32'hFFFF_FFE0);
      end
      n_checks++;
      if (r_rd_cycles !== (wr ? 0 : exp_len) || r_wr_cycles !== (wr ? exp_len : 0) ||
          r_resp_cycle !== exp_len + 1 || r_resp_count !== 1) begin
        n_fail++; $display("FAIL rand_%0d_timing: rd %0d wr %0d resp@%0d x%0d expected len %0d write %b", i, r_rd_cycles, r_wr_cycles, r_resp_cycle, r_resp_count, exp_len, wr);
      end
      if (wr) begin
        n_checks++;
        if (r_wbeats !== w || r_wdata_bad !== 0) begin
          n_fail++; $display("FAIL rand_%0d_wbeats: got %h (bad %0d) expected %h", i, r_wbeats, r_wdata_bad, w);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; line_read = 1'b0; line_write = 1'b0; line_addr = 32'h0;
    line_wdata = '0; burst_rdata = 64'h0; burst_resp = 1'b0;
    step;
    test_reset;
    test_read;
    test_write_gaps;
    test_write_priority;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
